// File: rtl/pong_pkg.sv
// pong_pkg: game phase encoding, screen geometry and colour constants shared by the Pong datapath
package pong_pkg;
  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2
  } state_e;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int EOF_Y    = 481;
  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
endpackage

// File: rtl/pong_frame_tick.sv
// pong_frame_tick: one-cycle strobe per video frame, raised the cycle after the raster reaches (0, EOF_Y)
module pong_frame_tick #(
  parameter int EOF_Y = pong_pkg::EOF_Y
) (
  input  logic       clk25M,
  input  logic       reset_n,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       tick_o
);
  logic tick_q;
  // register the end-of-frame pixel match so the strobe is glitch-free and one clock wide
  always_ff @(posedge clk25M or negedge reset_n)
    if (!reset_n) tick_q <= 1'b0;
    else tick_q <= x_i == '0 && y_i == 10'(EOF_Y);
  assign tick_o = tick_q;
endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball position, serve/score phases, wall and paddle reflection, speed-up per paddle hits
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int         BALL_SIZE        = 10,
  parameter int         PADDLE_H         = 64,
  parameter int         LEFT_FACE_X      = 30,
  parameter int         RIGHT_FACE_X     = 600,
  parameter int         TOP_WALL         = 3,
  parameter int         BOTTOM_WALL      = 477,
  parameter int         H_ACTIVE         = pong_pkg::H_ACTIVE,
  parameter int         V_ACTIVE         = pong_pkg::V_ACTIVE,
  parameter int         EOF_Y            = pong_pkg::EOF_Y,
  parameter int         SPEED_INIT       = 1,
  parameter int         SPEED_MAX        = 4,
  parameter int         HITS_PER_SPEEDUP = 4,
  parameter int         SERVE_FRAMES     = 60,
  parameter logic [2:0] COLOR            = pong_pkg::COLOR_GREEN
) (
  input  logic       clk25M,
  input  logic       reset_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] lpad_top,
  input  logic [9:0] rpad_top,
  output logic       ball_on,
  output logic [2:0] rgb,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit,
  output logic       score_left,
  output logic       score_right,
  output logic [1:0] state
);
  localparam logic [9:0]  SERVE_X = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  SERVE_Y = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
  localparam logic [10:0] BS1     = 11'(BALL_SIZE - 1);
  localparam logic [10:0] PH1     = 11'(PADDLE_H - 1);
  localparam logic [10:0] L_STOP  = 11'(LEFT_FACE_X + 1);
  localparam logic [10:0] R_STOP  = 11'(RIGHT_FACE_X - 1);
  localparam logic [10:0] Y_MIN   = 11'(TOP_WALL);
  localparam logic [10:0] Y_MAX   = 11'(BOTTOM_WALL - BALL_SIZE + 1);
  localparam logic [10:0] BOTTOM  = 11'(BOTTOM_WALL);
  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  state_e      state_q;
  logic [9:0]  bx_q, by_q;
  logic [3:0]  speed_q;
  logic [7:0]  serve_cnt_q, hit_cnt_q;
  logic        dx_q, dy_q, hit_q, sl_q, sr_q, tick;
  logic [10:0] bx, by, re, spd, lt, rt;
  logic [9:0]  bx_d, by_d;
  logic        dx_d, dy_d;
  logic        up_clip, dn_clip, l_front, r_front, l_hit, r_hit, l_out, r_out, paddle_hit;
  pong_frame_tick #(.EOF_Y(EOF_Y)) u_tick (
    .clk25M (clk25M),
    .reset_n(reset_n),
    .x_i    (x),
    .y_i    (y),
    .tick_o (tick)
  );
  assign bx  = {1'b0, bx_q};
  assign by  = {1'b0, by_q};
  assign re  = bx + BS1;
  assign spd = 11'(speed_q);
  assign lt  = {1'b0, lpad_top};
  assign rt  = {1'b0, rpad_top};
  // one frame of motion: wall clamps, paddle faces tested only while the ball is still in front of them
  always_comb begin
    up_clip    = by < Y_MIN + spd;
    dn_clip    = by + BS1 + spd > BOTTOM;
    l_front    = bx >= L_STOP && bx < L_STOP + spd;
    r_front    = re <= R_STOP && re + spd > R_STOP;
    l_hit      = !dx_q && l_front && by + BS1 >= lt && by <= lt + PH1;
    r_hit      = dx_q && r_front && by + BS1 >= rt && by <= rt + PH1;
    l_out      = !dx_q && bx < spd;
    r_out      = dx_q && re + spd > X_LAST;
    paddle_hit = l_hit | r_hit;
    by_d       = dy_q ? (dn_clip ? 10'(Y_MAX) : 10'(by + spd)) : (up_clip ? 10'(Y_MIN) : 10'(by - spd));
    dy_d       = dy_q ? !dn_clip : up_clip;
    bx_d       = l_hit ? 10'(L_STOP) : r_hit ? 10'(R_STOP - BS1) : dx_q ? 10'(bx + spd) : 10'(bx - spd);
    dx_d       = paddle_hit ? !dx_q : dx_q;
  end
  // game phase FSM; everything advances only on the frame strobe, pulses last one clock
  always_ff @(posedge clk25M or negedge reset_n)
    if (!reset_n) begin
      state_q     <= SERVE;
      bx_q        <= SERVE_X;
      by_q        <= SERVE_Y;
      speed_q     <= 4'(SPEED_INIT);
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      serve_cnt_q <= '0;
      hit_cnt_q   <= '0;
      hit_q       <= 1'b0;
      sl_q        <= 1'b0;
      sr_q        <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      sl_q  <= 1'b0;
      sr_q  <= 1'b0;
      if (tick)
        case (state_q)
          SERVE:
            if (serve_cnt_q == 8'(SERVE_FRAMES - 1)) begin
              state_q     <= MOVE;
              serve_cnt_q <= '0;
              speed_q     <= 4'(SPEED_INIT);
              hit_cnt_q   <= '0;
            end else serve_cnt_q <= serve_cnt_q + 8'd1;
          MOVE:
            if (l_out || r_out) begin
              state_q <= SCORED;
              sr_q    <= l_out;
              sl_q    <= r_out;
            end else begin
              bx_q  <= bx_d;
              by_q  <= by_d;
              dx_q  <= dx_d;
              dy_q  <= dy_d;
              hit_q <= paddle_hit;
              if (paddle_hit) begin
                hit_cnt_q <= hit_cnt_q == 8'(HITS_PER_SPEEDUP - 1) ? '0 : hit_cnt_q + 8'd1;
                if (hit_cnt_q == 8'(HITS_PER_SPEEDUP - 1) && speed_q != 4'(SPEED_MAX)) speed_q <= speed_q + 4'd1;
              end
            end
          default: begin
            state_q     <= SERVE;
            bx_q        <= SERVE_X;
            by_q        <= SERVE_Y;
            dy_q        <= !dy_q;
            serve_cnt_q <= '0;
          end
        endcase
    end
  assign ball_on     = state_q != SCORED && x >= bx_q && {1'b0, x} < bx + BSZ && y >= by_q && {1'b0, y} < by + BSZ;
  assign rgb         = ball_on ? COLOR : COLOR_BLACK;
  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign hit         = hit_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign state       = state_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed frame scenarios with a frame-indexed scoreboard and a rally speed-up check
module tb_pong_ball_engine;
  logic       clk25M = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x = 10'd5, y = 10'd100, lpad_top = 10'd300, rpad_top = 10'd400;
  logic       ball_on, hit, score_left, score_right;
  logic [2:0] rgb;
  logic [9:0] ball_x, ball_y;
  logic [1:0] state;
  logic [1:0] pipe = 2'b00;
  typedef struct {int frame; int bx; int by; int st; int hit; int sl; int sr;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, fcnt = 0, mframe = 0;
  int exp_spd[17] = '{0, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 4};

  pong_ball_engine dut (
    .clk25M(clk25M), .reset_n(reset_n), .x(x), .y(y), .lpad_top(lpad_top), .rpad_top(rpad_top),
    .ball_on(ball_on), .rgb(rgb), .ball_x(ball_x), .ball_y(ball_y), .hit(hit),
    .score_left(score_left), .score_right(score_right), .state(state)
  );

  always #20 clk25M = ~clk25M;

  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", n, act, req, $time);
    end
  endtask

  task automatic push(input int f, input int bx, input int by, input int st, input int h, input int sl, input int sr);
    exp_t t;
    t = '{f, bx, by, st, h, sl, sr};
    q.push_back(t);
  endtask

  task automatic frame();
    @(negedge clk25M);
    x = 10'd0;
    y = 10'd481;
    @(negedge clk25M);
    x = 10'd5;
    y = 10'd100;
    @(negedge clk25M);
    fcnt++;
  endtask

  task automatic check_on(input string n, input int xx, input int yy, input int req);
    x = 10'(xx);
    y = 10'(yy);
    #1;
    chk(n, ball_on, req);
    chk({n, "_rgb"}, rgb, req ? 2 : 0);
    x = 10'd5;
    y = 10'd100;
  endtask

  task automatic track();
    lpad_top = ball_y >= 10'd20 ? ball_y - 10'd20 : 10'd0;
    rpad_top = lpad_top;
  endtask

  always @(posedge clk25M) pipe <= {pipe[0], x == 10'd0 && y == 10'd481};

  initial forever begin
    @(negedge clk25M);
    if (pipe[1]) begin
      mframe++;
      if (q.size() > 0 && q[0].frame == mframe) begin
        e = q.pop_front();
        chk($sformatf("f%0d_ball_x", e.frame), ball_x, e.bx);
        chk($sformatf("f%0d_ball_y", e.frame), ball_y, e.by);
        chk($sformatf("f%0d_state", e.frame), state, e.st);
        chk($sformatf("f%0d_hit", e.frame), hit, e.hit);
        chk($sformatf("f%0d_score_left", e.frame), score_left, e.sl);
        chk($sformatf("f%0d_score_right", e.frame), score_right, e.sr);
      end
    end else if (reset_n) chk("pulse_idle", {hit, score_left, score_right}, 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int h, guard, hb, d, r;
    push(1, 315, 235, 0, 0, 0, 0);
    push(59, 315, 235, 0, 0, 0, 0);
    push(60, 315, 235, 1, 0, 0, 0);
    push(61, 316, 236, 1, 0, 0, 0);
    push(293, 548, 468, 1, 0, 0, 0);
    push(294, 549, 468, 1, 0, 0, 0);
    push(295, 550, 467, 1, 0, 0, 0);
    push(335, 590, 427, 1, 0, 0, 0);
    push(336, 590, 426, 1, 1, 0, 0);
    push(337, 589, 425, 1, 0, 0, 0);
    push(759, 167, 3, 1, 0, 0, 0);
    push(760, 166, 3, 1, 0, 0, 0);
    push(761, 165, 4, 1, 0, 0, 0);
    push(895, 31, 138, 1, 0, 0, 0);
    push(896, 30, 139, 1, 0, 0, 0);
    push(926, 0, 169, 1, 0, 0, 0);
    push(927, 0, 169, 2, 0, 0, 1);
    push(928, 315, 235, 0, 0, 0, 0);
    push(987, 315, 235, 0, 0, 0, 0);
    push(988, 315, 235, 1, 0, 0, 0);
    push(989, 314, 234, 1, 0, 0, 0);
    push(1220, 83, 3, 1, 0, 0, 0);
    push(1221, 82, 3, 1, 0, 0, 0);
    push(1222, 81, 4, 1, 0, 0, 0);
    push(1272, 31, 54, 1, 0, 0, 0);
    push(1273, 31, 55, 1, 1, 0, 0);
    push(1274, 32, 56, 1, 0, 0, 0);
    #30;
    chk("reset_state", state, 0);
    chk("reset_ball_x", ball_x, 315);
    chk("reset_ball_y", ball_y, 235);
    chk("reset_pulses", {hit, score_left, score_right}, 0);
    check_on("reset_on_corner", 315, 235, 1);
    check_on("reset_on_far", 324, 244, 1);
    check_on("reset_off_right", 325, 235, 0);
    check_on("reset_off_below", 320, 245, 0);
    @(negedge clk25M);
    reset_n = 1'b1;
    repeat (927) frame();
    check_on("scored_hidden", 0, 169, 0);
    frame();
    check_on("serve_visible", 315, 235, 1);
    lpad_top = 10'd30;
    repeat (346) frame();
    h = 1;
    guard = 0;
    while (h < 16 && guard < 12000) begin
      track();
      frame();
      guard++;
      if (hit) begin
        h++;
        hb = int'(ball_x);
        track();
        frame();
        d = int'(ball_x) - hb;
        chk($sformatf("hit%0d_pos", h), int'(hb == 31 || hb == 590), 1);
        chk($sformatf("hit%0d_speed", h), d < 0 ? -d : d, exp_spd[h]);
      end
    end
    chk("rally_hits", h, 16);
    chk("rally_state", state, 1);
    @(negedge clk25M);
    #5;
    reset_n = 1'b0;
    #1;
    chk("midreset_state", state, 0);
    chk("midreset_ball_x", ball_x, 315);
    chk("midreset_ball_y", ball_y, 235);
    chk("midreset_pulses", {hit, score_left, score_right}, 0);
    check_on("midreset_on", 320, 240, 1);
    @(negedge clk25M);
    reset_n = 1'b1;
    lpad_top = 10'd300;
    rpad_top = 10'd400;
    r = fcnt;
    push(r + 59, 315, 235, 0, 0, 0, 0);
    push(r + 60, 315, 235, 1, 0, 0, 0);
    push(r + 61, 316, 236, 1, 0, 0, 0);
    repeat (61) frame();
    repeat (2) @(negedge clk25M);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
